// File: rtl/code_entry_checker.sv
// code_entry_checker: collects keypad digits into a zero-padded entry buffer,
// verifies it against the passcode or user code, runs the two-step enroll /
// confirm flow for a new user code, and locks the keypad out for a fixed
// number of cycles after too many consecutive failed verifications.
module code_entry_checker #(
  parameter int          DIGITS         = 6,
  parameter int          MIN_DIGITS     = 4,
  parameter logic [3:0]  CLEAR_KEY      = 4'd7,
  parameter logic [3:0]  ENTER_KEY      = 4'd8,
  parameter int          MAX_FAILS      = 3,
  parameter logic [23:0] LOCKOUT_CYCLES = 24'd12_000_000
) (
  input  logic                             hwclk_i,
  input  logic                             rst_n_i,
  input  logic                             key_valid_i,
  input  logic [3:0]                       key_i,
  input  logic [1:0]                       mode_i,
  input  logic [4*DIGITS-1:0]              correct_pc_i,
  input  logic [4*DIGITS-1:0]              correct_uc_i,
  output logic                             result_valid_o,
  output logic                             result_ok_o,
  output logic [4*DIGITS-1:0]              new_uc_o,
  output logic                             new_uc_valid_o,
  output logic                             locked_out_o,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count_o,
  output logic [$clog2(DIGITS+1)-1:0]      entry_count_o
);

  localparam int BW = 4 * DIGITS;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [CW-1:0] DIGITS_C   = CW'(DIGITS);
  localparam logic [CW-1:0] MIN_C      = CW'(MIN_DIGITS);
  localparam logic [FW-1:0] MAX_FAIL_C = FW'(MAX_FAILS);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] entryBuf_q, entryBuf_d;
  logic [CW-1:0] entryCnt_q, entryCnt_d;
  logic [BW-1:0] pending_q, pending_d;
  logic [FW-1:0] failCnt_q, failCnt_d;
  logic [23:0]   lockCnt_q, lockCnt_d;
  logic [1:0]    modePrev_q;
  logic          resultValid_q, resultValid_d;
  logic          resultOk_q, resultOk_d;
  logic [BW-1:0] newUc_q, newUc_d;
  logic          newUcValid_q, newUcValid_d;

  logic          modeChanged;
  logic          keyLive;
  logic          tooShort;
  logic [BW-1:0] targetCode;
  logic [FW-1:0] failInc;

  // A mode change is detected against last cycle's mode and takes priority over any key.
  assign modeChanged = (mode_i != modePrev_q);
  assign keyLive     = key_valid_i && (mode_i != 2'b11) && !modeChanged;
  assign tooShort    = (entryCnt_q < MIN_C);
  assign targetCode  = mode_i[0] ? correct_uc_i : correct_pc_i;
  assign failInc     = failCnt_q + 1'b1;

  // State and datapath registers; everything returns to zero on reset.
  always_ff @(posedge hwclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ENTRY;
      entryBuf_q    <= '0;
      entryCnt_q    <= '0;
      pending_q     <= '0;
      failCnt_q     <= '0;
      lockCnt_q     <= '0;
      modePrev_q    <= 2'b00;
      resultValid_q <= 1'b0;
      resultOk_q    <= 1'b0;
      newUc_q       <= '0;
      newUcValid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      entryBuf_q    <= entryBuf_d;
      entryCnt_q    <= entryCnt_d;
      pending_q     <= pending_d;
      failCnt_q     <= failCnt_d;
      lockCnt_q     <= lockCnt_d;
      modePrev_q    <= mode_i;
      resultValid_q <= resultValid_d;
      resultOk_q    <= resultOk_d;
      newUc_q       <= newUc_d;
      newUcValid_q  <= newUcValid_d;
    end
  end

  // Next-state logic: key handling in ENTRY/CONFIRM, countdown in LOCKED.
  always_comb begin
    state_d       = state_q;
    entryBuf_d    = entryBuf_q;
    entryCnt_d    = entryCnt_q;
    pending_d     = pending_q;
    failCnt_d     = failCnt_q;
    lockCnt_d     = lockCnt_q;
    resultValid_d = 1'b0;
    resultOk_d    = resultOk_q;
    newUc_d       = newUc_q;
    newUcValid_d  = 1'b0;

    case (state_q)
      LOCKED: begin
        if (lockCnt_q == 24'd0) begin
          failCnt_d = '0;
          state_d   = ENTRY;
        end else begin
          lockCnt_d = lockCnt_q - 24'd1;
        end
      end

      default: begin
        if (modeChanged) begin
          entryBuf_d = '0;
          entryCnt_d = '0;
          state_d    = ENTRY;
        end else if (keyLive) begin
          if (key_i == CLEAR_KEY) begin
            entryBuf_d = '0;
            entryCnt_d = '0;
          end else if (key_i == ENTER_KEY) begin
            entryBuf_d = '0;
            entryCnt_d = '0;
            if (state_q == CONFIRM) begin
              resultValid_d = 1'b1;
              state_d       = ENTRY;
              if (!tooShort && (entryBuf_q == pending_q)) begin
                resultOk_d   = 1'b1;
                newUc_d      = pending_q;
                newUcValid_d = 1'b1;
              end else begin
                resultOk_d = 1'b0;
              end
            end else if (tooShort) begin
              resultValid_d = 1'b1;
              resultOk_d    = 1'b0;
            end else if (mode_i == 2'b10) begin
              pending_d = entryBuf_q;
              state_d   = CONFIRM;
            end else begin
              resultValid_d = 1'b1;
              if (entryBuf_q == targetCode) begin
                resultOk_d = 1'b1;
                failCnt_d  = '0;
              end else begin
                resultOk_d = 1'b0;
                failCnt_d  = failInc;
                if (failInc == MAX_FAIL_C) begin
                  state_d   = LOCKED;
                  lockCnt_d = LOCKOUT_CYCLES - 24'd1;
                end
              end
            end
          end else begin
            entryBuf_d = (entryBuf_q << 4) | BW'(key_i);
            if (entryCnt_q != DIGITS_C) begin
              entryCnt_d = entryCnt_q + 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign result_valid_o = resultValid_q;
  assign result_ok_o    = resultOk_q;
  assign new_uc_o       = newUc_q;
  assign new_uc_valid_o = newUcValid_q;
  assign locked_out_o   = (state_q == LOCKED);
  assign fail_count_o   = failCnt_q;
  assign entry_count_o  = entryCnt_q;

endmodule

// File: tb/tb_code_entry_checker.sv
// tb_code_entry_checker: directed bench for code_entry_checker with a result
// scoreboard. Each submit that should produce a result pushes the expected
// outcome and its due cycle; a monitor pops and compares when result_valid fires.
module tb_code_entry_checker;

  localparam logic [3:0] CLEAR = 4'hA;
  localparam logic [3:0] ENTER = 4'hB;

  logic        hwclk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key;
  logic [1:0]  mode;
  logic [23:0] correct_pc;
  logic [23:0] correct_uc;
  logic        result_valid;
  logic        result_ok;
  logic [23:0] new_uc;
  logic        new_uc_valid;
  logic        locked_out;
  logic [1:0]  fail_count;
  logic [2:0]  entry_count;

  typedef struct {
    logic        ok;
    logic        nuv;
    logic [23:0] uc;
    int          due;
  } exp_t;

  exp_t        sbQ[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          hi;
  logic [23:0] expUc = 24'h0;

  code_entry_checker #(
    .DIGITS(6), .MIN_DIGITS(4), .CLEAR_KEY(CLEAR), .ENTER_KEY(ENTER),
    .MAX_FAILS(3), .LOCKOUT_CYCLES(24'd10)
  ) dut (
    .hwclk_i(hwclk), .rst_n_i(rst_n), .key_valid_i(key_valid), .key_i(key),
    .mode_i(mode), .correct_pc_i(correct_pc), .correct_uc_i(correct_uc),
    .result_valid_o(result_valid), .result_ok_o(result_ok), .new_uc_o(new_uc),
    .new_uc_valid_o(new_uc_valid), .locked_out_o(locked_out),
    .fail_count_o(fail_count), .entry_count_o(entry_count)
  );

  // Free-running clock, period 10.
  always #5 hwclk = ~hwclk;

  // Cycle counter used to time-stamp expected results.
  always @(posedge hwclk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic kv, input logic [3:0] k);
    @(posedge hwclk);
    #1;
    key_valid = kv;
    key       = k;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 4'd0);
  endtask

  task automatic setMode(input logic [1:0] m);
    @(posedge hwclk);
    #1;
    mode      = m;
    key_valid = 1'b0;
  endtask

  // Types n digits taken from the low nibbles of code, most significant first.
  task automatic typeCode(input logic [31:0] code, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, code[4*i +: 4]);
  endtask

  task automatic submit(input logic ok, input logic nuv, input logic [23:0] uc);
    exp_t e;
    applyStimulus(1'b1, ENTER);
    e.ok  = ok;
    e.nuv = nuv;
    e.uc  = uc;
    e.due = cyc + 1;
    sbQ.push_back(e);
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, "_result_valid"}, result_valid, 0);
    checkOutput({tag, "_result_ok"}, result_ok, 0);
    checkOutput({tag, "_new_uc"}, new_uc, 0);
    checkOutput({tag, "_new_uc_valid"}, new_uc_valid, 0);
    checkOutput({tag, "_locked_out"}, locked_out, 0);
    checkOutput({tag, "_fail_count"}, fail_count, 0);
    checkOutput({tag, "_entry_count"}, entry_count, 0);
  endtask

  // Result monitor: every result pulse must match the oldest expectation, on time.
  always @(negedge hwclk) begin
    exp_t e;
    if (rst_n) begin
      if (!result_valid) checkOutput("nuv_without_result", new_uc_valid, 0);
      if (result_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_result", result_valid, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("result_cycle", cyc, e.due);
          checkOutput("result_ok", result_ok, e.ok);
          checkOutput("new_uc_valid", new_uc_valid, e.nuv);
          checkOutput("new_uc", new_uc, e.uc);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key = 4'd0; mode = 2'b00;
    correct_pc = 24'h123456; correct_uc = 24'h004521;
    repeat (3) @(negedge hwclk);
    resetChecks("reset");
    @(posedge hwclk); #1 rst_n = 1'b1;

    // Correct passcode.
    typeCode(32'h123456, 6);
    submit(1'b1, 1'b0, expUc);
    idleCycle(); @(negedge hwclk);
    checkOutput("pc_ok_fail_count", fail_count, 0);
    checkOutput("pc_ok_entry_cleared", entry_count, 0);

    // User code: wrong, too short, then correct.
    setMode(2'b01);
    typeCode(32'h4522, 4);
    submit(1'b0, 1'b0, expUc);
    idleCycle(); @(negedge hwclk);
    checkOutput("uc_wrong_fail_count", fail_count, 1);
    typeCode(32'h521, 3);
    submit(1'b0, 1'b0, expUc);
    idleCycle(); @(negedge hwclk);
    checkOutput("short_fail_count_kept", fail_count, 1);
    typeCode(32'h4521, 4);
    submit(1'b1, 1'b0, expUc);
    idleCycle(); @(negedge hwclk);
    checkOutput("uc_ok_fail_cleared", fail_count, 0);

    // Enroll: matching confirm, then mismatching confirm.
    setMode(2'b10);
    typeCode(32'h9314, 4);
    applyStimulus(1'b1, ENTER);
    idleCycle(); @(negedge hwclk);
    checkOutput("enroll_first_entry_cleared", entry_count, 0);
    typeCode(32'h9314, 4);
    expUc = 24'h009314;
    submit(1'b1, 1'b1, expUc);
    idleCycle(); @(negedge hwclk); @(negedge hwclk);
    checkOutput("new_uc_valid_one_cycle", new_uc_valid, 0);
    checkOutput("new_uc_held", new_uc, 24'h009314);
    typeCode(32'h9314, 4);
    applyStimulus(1'b1, ENTER);
    typeCode(32'h9315, 4);
    submit(1'b0, 1'b0, expUc);

    // Overflow: eight digits keep the last six.
    setMode(2'b00);
    correct_pc = 24'h345678;
    typeCode(32'h12345678, 8);
    idleCycle(); @(negedge hwclk);
    checkOutput("entry_count_saturates", entry_count, 6);
    submit(1'b1, 1'b0, expUc);

    // Clear mid-entry.
    typeCode(32'h123, 3);
    applyStimulus(1'b1, CLEAR);
    idleCycle(); @(negedge hwclk);
    checkOutput("clear_mid_entry", entry_count, 0);

    // Mode change and key in the same cycle: key dropped.
    @(posedge hwclk); #1 mode = 2'b01; key_valid = 1'b1; key = 4'd5;
    idleCycle(); @(negedge hwclk);
    checkOutput("key_dropped_on_mode_change", entry_count, 0);
    typeCode(32'h12, 2);
    setMode(2'b10);
    idleCycle(); @(negedge hwclk);
    checkOutput("mode_change_clears_buffer", entry_count, 0);

    // Mode change during CONFIRM abandons it without a result.
    typeCode(32'h9314, 4);
    applyStimulus(1'b1, ENTER);
    setMode(2'b00);
    setMode(2'b10);
    typeCode(32'h9314, 4);
    applyStimulus(1'b1, ENTER);
    setMode(2'b00);
    idleCycle(); @(negedge hwclk);
    checkOutput("abandon_confirm_new_uc", new_uc, 24'h009314);

    // Lockout after three wrong passcodes; keys and mode changes ignored.
    correct_pc = 24'h123456;
    for (int n = 0; n < 3; n++) begin
      typeCode(32'h1111, 4);
      submit(1'b0, 1'b0, expUc);
    end
    idleCycle(); @(negedge hwclk);
    checkOutput("lock_rise", locked_out, 1);
    checkOutput("fail_count_at_lock", fail_count, 3);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge hwclk);
      if (!locked_out) begin
        key_valid = 1'b1; key = 4'd5;
        break;
      end
      hi++;
      key_valid = 1'b1;
      key = (i % 2 == 1) ? ENTER : 4'd2;
      if (hi == 3) mode = 2'b01;
      if (hi == 5) mode = 2'b00;
    end
    @(posedge hwclk); #1 key_valid = 1'b0;
    @(negedge hwclk);
    checkOutput("lock_length", hi, 10);
    checkOutput("unlock_fail_count", fail_count, 0);
    checkOutput("first_key_after_unlock", entry_count, 1);
    applyStimulus(1'b1, CLEAR);

    // Reset during LOCKED.
    for (int n = 0; n < 3; n++) begin
      typeCode(32'h2222, 4);
      submit(1'b0, 1'b0, expUc);
    end
    idleCycle();
    repeat (3) @(negedge hwclk);
    checkOutput("locked_before_reset", locked_out, 1);
    #2 rst_n = 1'b0;
    #1 resetChecks("reset_in_lock");
    @(posedge hwclk); #1 rst_n = 1'b1;
    expUc = 24'h0;
    typeCode(32'h123456, 6);
    submit(1'b1, 1'b0, expUc);

    // Reset during CONFIRM.
    setMode(2'b10);
    typeCode(32'h1234, 4);
    applyStimulus(1'b1, ENTER);
    typeCode(32'h1234, 4);
    expUc = 24'h001234;
    submit(1'b1, 1'b1, expUc);
    typeCode(32'h9314, 4);
    applyStimulus(1'b1, ENTER);
    applyStimulus(1'b1, 4'd9);
    idleCycle(); @(negedge hwclk);
    checkOutput("entry_in_confirm", entry_count, 1);
    #2 rst_n = 1'b0; mode = 2'b00;
    #1 resetChecks("reset_in_confirm");
    @(posedge hwclk); #1 rst_n = 1'b1;
    expUc = 24'h0;
    typeCode(32'h123456, 6);
    submit(1'b1, 1'b0, expUc);
    idleCycle(); idleCycle(); @(negedge hwclk);
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
